// File: rtl/rr_pkg.sv
// rr_pkg: shared state encoding and counter-width helpers for the round-robin arbiter blocks
package rr_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;
    function automatic int clogb2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
    function automatic int cnt_w(input int limit);
        return clogb2(limit + 1);
    endfunction
endpackage

// File: rtl/rr_watchdog.sv
// rr_watchdog: counts enabled cycles without a kick and flags when the limit is reached
module rr_watchdog
    import rr_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic nrst,
    input  logic en_i,
    input  logic kick_i,
    output logic expire_o
);
    localparam int IW = cnt_w(TIMEOUT);
    localparam logic [IW-1:0] LIMIT = IW'(TIMEOUT - 1);
    localparam logic [IW-1:0] SAT = IW'(TIMEOUT);
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    assign expire_o = en_i && !kick_i && idle_cnt_q == LIMIT;
    always_comb
        idle_cnt_d = (!en_i || kick_i) ? '0 : (idle_cnt_q == SAT) ? idle_cnt_q : idle_cnt_q + 1'b1;
    always_ff @(posedge clk)
        idle_cnt_q <= !nrst ? '0 : idle_cnt_d;
endmodule

// File: rtl/rr_grant_sequencer.sv
// rr_grant_sequencer: turns encoder selections into a registered one-hot burst grant with release and watchdog
module rr_grant_sequencer
    import rr_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int WIDTH_W   = clogb2(WIDTH),
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [WIDTH-1:0]   req_i,
    input  logic               enc_valid_i,
    input  logic [WIDTH_W-1:0] enc_bin_i,
    input  logic               beat_i,
    input  logic               last_i,
    output logic [WIDTH-1:0]   gnt_o,
    output logic               gnt_valid_o,
    output logic [WIDTH_W-1:0] gnt_bin_o,
    output logic               timeout_err_o,
    output logic               busy_o
);
    localparam int BW = cnt_w(MAX_BURST);
    localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
    localparam logic [BW-1:0] BEAT_SAT = BW'(MAX_BURST);
    state_e state_q, state_d;
    logic [WIDTH_W-1:0] owner_q, owner_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic [WIDTH-1:0] gnt_q, gnt_d;
    logic gnt_valid_q, gnt_valid_d;
    logic [WIDTH_W-1:0] gnt_bin_q, gnt_bin_d;
    logic timeout_err_q, timeout_err_d;
    logic busy_q, busy_d;
    logic granted, req_own, expire, done;
    assign granted = state_q == GRANT;
    assign req_own = req_i[owner_q];
    // expire already excludes beat cycles, so the watchdog can only win when no beat exit applies
    assign done = (beat_i && (last_i || beat_cnt_q == BEAT_LAST)) || !req_own || expire;
    rr_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk      (clk),
        .nrst     (nrst),
        .en_i     (granted),
        .kick_i   (beat_i),
        .expire_o (expire)
    );
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        beat_cnt_d    = beat_cnt_q;
        timeout_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enc_valid_i && req_i[enc_bin_i]) begin
                    state_d    = GRANT;
                    owner_d    = enc_bin_i;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                beat_cnt_d    = !beat_i ? beat_cnt_q : (beat_cnt_q == BEAT_SAT) ? beat_cnt_q : beat_cnt_q + 1'b1;
                state_d       = done ? RELEASE : GRANT;
                timeout_err_d = req_own && expire;
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        gnt_valid_d = state_d == GRANT;
        gnt_d       = gnt_valid_d ? WIDTH'(1) << owner_d : '0;
        gnt_bin_d   = gnt_valid_d ? owner_d : '0;
        busy_d      = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            beat_cnt_q    <= '0;
            gnt_q         <= '0;
            gnt_valid_q   <= 1'b0;
            gnt_bin_q     <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            beat_cnt_q    <= beat_cnt_d;
            gnt_q         <= gnt_d;
            gnt_valid_q   <= gnt_valid_d;
            gnt_bin_q     <= gnt_bin_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
        end
    end
    assign gnt_o         = gnt_q;
    assign gnt_valid_o   = gnt_valid_q;
    assign gnt_bin_o     = gnt_bin_q;
    assign timeout_err_o = timeout_err_q;
    assign busy_o        = busy_q;
endmodule

// File: tb/tb_rr_grant_sequencer.sv
// tb_rr_grant_sequencer: directed scenarios plus a randomized fairness run against an encoder model
module tb_rr_grant_sequencer;
    localparam int W = 8;
    localparam int WW = 3;
    localparam int MB = 4;
    localparam int TO = 5;
    localparam int WAIT_LIMIT = W * (MB * TO + 5);
    logic clk = 1'b0;
    logic nrst;
    logic [W-1:0] req, gnt;
    logic enc_valid, beat, last, gnt_valid, timeout_err, busy;
    logic [WW-1:0] enc_bin, gnt_bin;
    int vectors = 0;
    int miscompares = 0;

    rr_grant_sequencer #(.WIDTH(W), .WIDTH_W(WW), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .req_i         (req),
        .enc_valid_i   (enc_valid),
        .enc_bin_i     (enc_bin),
        .beat_i        (beat),
        .last_i        (last),
        .gnt_o         (gnt),
        .gnt_valid_o   (gnt_valid),
        .gnt_bin_o     (gnt_bin),
        .timeout_err_o (timeout_err),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        req = '0; enc_valid = 1'b0; enc_bin = '0; beat = 1'b0; last = 1'b0;
    endtask

    task automatic drain();
        quiet();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        quiet();
        nrst = 1'b0;
        tick(); tick();
        vectors++;
        if ({gnt, gnt_valid, gnt_bin, timeout_err, busy} !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0", {gnt, gnt_valid, gnt_bin, timeout_err, busy});
        end
        nrst = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0 || gnt !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b gnt=%h expected busy=0 gnt=00", busy, gnt);
        end
    endtask

    task automatic test_basic();
        req = 8'h10; enc_valid = 1'b1; enc_bin = 3'd4;
        tick();
        enc_valid = 1'b0;
        vectors++;
        if (gnt !== 8'h10 || gnt_valid !== 1'b1 || gnt_bin !== 3'd4 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_grant: got gnt=%h v=%b bin=%0d busy=%b expected 10 1 4 1", gnt, gnt_valid, gnt_bin, busy);
        end
        tick(); tick();
        vectors++;
        if (gnt !== 8'h10) begin
            miscompares++;
            $display("FAIL basic_hold: got gnt=%h expected 10", gnt);
        end
        beat = 1'b1; last = 1'b1;
        tick();
        beat = 1'b0; last = 1'b0;
        vectors++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || busy !== 1'b1 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_release: got gnt=%h v=%b busy=%b err=%b expected 00 0 1 0", gnt, gnt_valid, busy, timeout_err);
        end
        tick();
        vectors++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_idle: got gnt=%h busy=%b expected 00 0", gnt, busy);
        end
        drain();
    endtask

    task automatic test_burst_cap();
        int n;
        req = 8'h04; enc_valid = 1'b1; enc_bin = 3'd2; beat = 1'b1;
        tick();
        n = 0;
        while (gnt === 8'h04 && n < 8) begin
            n++;
            tick();
        end
        vectors++;
        if (n !== MB) begin
            miscompares++;
            $display("FAIL burst_beats: got %0d beats expected %0d", n, MB);
        end
        vectors++;
        if (gnt !== 8'h00 || busy !== 1'b1 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_release: got gnt=%h busy=%b err=%b expected 00 1 0", gnt, busy, timeout_err);
        end
        beat = 1'b0;
        tick();
        vectors++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_dead_cycle: got gnt=%h busy=%b expected 00 0", gnt, busy);
        end
        tick();
        vectors++;
        if (gnt !== 8'h04 || gnt_bin !== 3'd2) begin
            miscompares++;
            $display("FAIL burst_regrant: got gnt=%h bin=%0d expected 04 2", gnt, gnt_bin);
        end
        drain();
    endtask

    task automatic test_withdraw();
        req = 8'h81; enc_valid = 1'b1; enc_bin = 3'd7;
        tick();
        enc_valid = 1'b0; beat = 1'b1;
        tick();
        beat = 1'b0;
        vectors++;
        if (gnt !== 8'h80 || gnt_bin !== 3'd7) begin
            miscompares++;
            $display("FAIL withdraw_hold: got gnt=%h bin=%0d expected 80 7", gnt, gnt_bin);
        end
        req = 8'h01;
        tick();
        vectors++;
        if (gnt !== 8'h00 || busy !== 1'b1 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL withdraw_release: got gnt=%h busy=%b err=%b expected 00 1 0", gnt, busy, timeout_err);
        end
        tick();
        vectors++;
        if (gnt !== 8'h00 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL withdraw_idle: got gnt=%h busy=%b err=%b expected 00 0 0", gnt, busy, timeout_err);
        end
        drain();
    endtask

    task automatic test_watchdog();
        req = 8'h02; enc_valid = 1'b1; enc_bin = 3'd1;
        tick();
        enc_valid = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            vectors++;
            if (gnt !== 8'h02 || timeout_err !== 1'b0) begin
                miscompares++;
                $display("FAIL wd_hold cycle %0d: got gnt=%h err=%b expected 02 0", i, gnt, timeout_err);
            end
            tick();
        end
        vectors++;
        if (gnt !== 8'h00 || timeout_err !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wd_release: got gnt=%h err=%b busy=%b expected 00 1 1", gnt, timeout_err, busy);
        end
        tick();
        vectors++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL wd_pulse_width: got err=%b busy=%b expected 0 0", timeout_err, busy);
        end
        enc_valid = 1'b1;
        tick();
        enc_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            vectors++;
            if (gnt !== 8'h02 || timeout_err !== 1'b0) begin
                miscompares++;
                $display("FAIL wd_kick cycle %0d: got gnt=%h err=%b expected 02 0", i, gnt, timeout_err);
            end
            beat = (i == 4);
            tick();
        end
        beat = 1'b0; req = 8'h00;
        tick();
        vectors++;
        if (gnt !== 8'h00 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL wd_kick_release: got gnt=%h err=%b expected 00 0", gnt, timeout_err);
        end
        drain();
    endtask

    task automatic test_simultaneous();
        req = 8'h08; enc_valid = 1'b1; enc_bin = 3'd3;
        tick();
        enc_valid = 1'b0; beat = 1'b1;
        tick(); tick(); tick();
        vectors++;
        if (gnt !== 8'h08) begin
            miscompares++;
            $display("FAIL sim_hold: got gnt=%h expected 08", gnt);
        end
        last = 1'b1; req = 8'h00;
        tick();
        beat = 1'b0; last = 1'b0;
        vectors++;
        if (gnt !== 8'h00 || busy !== 1'b1 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL sim_release: got gnt=%h busy=%b err=%b expected 00 1 0", gnt, busy, timeout_err);
        end
        tick();
        vectors++;
        if (gnt !== 8'h00 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL sim_single_release: got gnt=%h busy=%b err=%b expected 00 0 0", gnt, busy, timeout_err);
        end
        req = 8'hDF; enc_valid = 1'b1; enc_bin = 3'd5;
        tick(); tick();
        vectors++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_valid: got gnt=%h busy=%b expected 00 0", gnt, busy);
        end
        drain();
    endtask

    task automatic test_reset_mid_grant();
        req = 8'h40; enc_valid = 1'b1; enc_bin = 3'd6;
        tick();
        enc_valid = 1'b0;
        tick();
        vectors++;
        if (gnt !== 8'h40) begin
            miscompares++;
            $display("FAIL rst_mid_hold: got gnt=%h expected 40", gnt);
        end
        nrst = 1'b0;
        tick();
        vectors++;
        if ({gnt, gnt_valid, gnt_bin, timeout_err, busy} !== 14'h0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got %h expected 0", {gnt, gnt_valid, gnt_bin, timeout_err, busy});
        end
        nrst = 1'b1; req = 8'h00;
        tick();
        vectors++;
        if (busy !== 1'b0 || timeout_err !== 1'b0 || gnt !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_mid_after: got busy=%b err=%b gnt=%h expected 0 0 00", busy, timeout_err, gnt);
        end
        drain();
    endtask

    task automatic test_fairness();
        logic [WW-1:0] ptr, idx;
        logic [W-1:0] served, r;
        logic found;
        int wait_c [W];
        int max_wait [W];
        int grants [W];
        ptr = '0; served = '0;
        quiet();
        for (int i = 0; i < W; i++) begin
            wait_c[i] = 0; max_wait[i] = 0; grants[i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            vectors++;
            if ($countones(gnt) > 1 || gnt_valid !== (gnt != 8'h00) || gnt !== (gnt_valid ? W'(1) << gnt_bin : W'(0))) begin
                miscompares++;
                $display("FAIL fair_onehot cycle %0d: got gnt=%h v=%b bin=%0d expected consistent one-hot", c, gnt, gnt_valid, gnt_bin);
            end
            if (gnt_valid) ptr = gnt_bin + 1'b1;
            r = req; beat = 1'b0; last = 1'b0;
            for (int i = 0; i < W; i++) begin
                if (gnt[i]) begin
                    if (!served[i]) grants[i]++;
                    served[i] = 1'b1;
                    wait_c[i] = 0;
                    beat = $urandom_range(0, 3) != 0;
                    last = beat && $urandom_range(0, 7) == 0;
                    if ($urandom_range(0, 31) == 0) r[i] = 1'b0;
                end else if (served[i]) begin
                    served[i] = 1'b0;
                    wait_c[i] = 0;
                    r[i] = $urandom_range(0, 1) == 1;
                end else if (!r[i]) begin
                    r[i] = $urandom_range(0, 7) == 0;
                end else begin
                    wait_c[i]++;
                    if (wait_c[i] > max_wait[i]) max_wait[i] = wait_c[i];
                end
            end
            req = r; enc_valid = |r; enc_bin = ptr; found = 1'b0;
            for (int k = 0; k < W; k++) begin
                idx = ptr + WW'(k);
                if (!found && r[idx]) begin
                    enc_bin = idx;
                    found = 1'b1;
                end
            end
            tick();
        end
        for (int i = 0; i < W; i++) begin
            vectors++;
            if (grants[i] == 0) begin
                miscompares++;
                $display("FAIL fair_granted idx %0d: got 0 grants expected at least 1", i);
            end
            vectors++;
            if (max_wait[i] > WAIT_LIMIT) begin
                miscompares++;
                $display("FAIL fair_wait idx %0d: got %0d cycles expected at most %0d", i, max_wait[i], WAIT_LIMIT);
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_burst_cap();
        test_withdraw();
        test_watchdog();
        test_simultaneous();
        test_reset_mid_grant();
        test_fairness();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
